spi_cmd_decoder: RTL

- Consumes the byte stream produced by the SPI slave, already transferred into the system clock domain as one-cycle `in_rx_valid` strobes plus a synchronized chip-select level.
- Decodes a command/address header, then performs auto-incrementing register writes or reads against an external register bank.
- Returns readback bytes to the SPI slave's transmit side.
- Sits between the SPI slave and the control/status register file of the control FPGA.

---
 rtl/spi_cmd_pkg.sv | 28 ++
 rtl/spi_cmd_decoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cmd_pkg
//  Description : Shared types and constants for the SPI command decoder:
//                FSM state encoding, command-byte field positions, error
//                counter ceiling and the default frame-start sync byte.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_cmd_pkg;

    // Decoder FSM states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DROP  = 3'd4
    } state_e;

    // Command byte bit that selects read (1) or write (0).
    localparam int         CMD_RD_BIT        = 7;
    // Rejected-frame counter ceiling.
    localparam logic [7:0] ERR_COUNT_MAX     = 8'hFF;
    // Byte shifted out while the command byte is being received.
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage : spi_cmd_pkg
`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cmd_decoder
//  Description : Decodes the SPI byte stream (already in the in_clk domain)
//                into auto-incrementing register-bank writes and reads, and
//                returns readback bytes to the SPI slave transmit side.
//  Revision    : 1.0 - initial release
//
//  Ports
//    in_clk        system clock
//    in_rst_n      asynchronous active-low reset
//    in_cs_n       synchronized frame select, low = frame active
//    in_rx_valid   one-cycle strobe, in_rx_byte holds a received byte
//    in_rx_byte    received byte
//    o_tx_byte     byte for the SPI slave to shift out next
//    o_tx_valid    one-cycle strobe when o_tx_byte is updated
//    o_reg_addr    register address
//    o_reg_wdata   register write data
//    o_reg_wr_en   one-cycle register write strobe
//    o_reg_rd_en   one-cycle register read strobe (rdata valid next cycle)
//    in_reg_rdata  register read data
//    o_err_count   saturating count of rejected frames
// ============================================================================
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int         NUM_REGS  = 16,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         ADDR_W    = 7
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_cs_n,
    input  logic              in_rx_valid,
    input  logic [7:0]        in_rx_byte,
    output logic [7:0]        o_tx_byte,
    output logic              o_tx_valid,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [7:0]        o_reg_wdata,
    output logic              o_reg_wr_en,
    output logic              o_reg_rd_en,
    input  logic [7:0]        in_reg_rdata,
    output logic [7:0]        o_err_count
);

    localparam logic [ADDR_W:0]   c_NUM_REGS  = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_e            state_q;
    logic              cs_prev_q;   // in_cs_n of the previous cycle
    logic              rd_pend_q;   // read issued last cycle, rdata valid now
    logic [7:0]        tx_byte_q;
    logic              tx_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              wr_en_q;
    logic              rd_en_q;
    logic [7:0]        err_q;

    logic              w_cmd_is_rd;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic              w_addr_legal;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_cmd_is_rd  = in_rx_byte[CMD_RD_BIT];
    assign w_cmd_addr   = in_rx_byte[ADDR_W-1:0];
    assign w_addr_legal = ({1'b0, w_cmd_addr} < c_NUM_REGS);
    // Auto-increment wraps at the top of the register bank, not at 2**ADDR_W.
    assign w_addr_inc   = (addr_q == c_LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q    <= ST_IDLE;
            cs_prev_q  <= 1'b0;   // forces a high cs_n to be seen before a frame
            rd_pend_q  <= 1'b0;
            tx_byte_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            err_q      <= '0;
        end else begin
            cs_prev_q  <= in_cs_n;
            tx_valid_q <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;

            // Read pipeline runs independently of the FSM so that a read in
            // flight when the frame ends still completes.
            rd_pend_q <= rd_en_q;
            if (rd_pend_q) begin
                tx_byte_q  <= in_reg_rdata;
                tx_valid_q <= 1'b1;
            end

            // Write address advances the cycle after each write strobe.
            if (wr_en_q) begin
                addr_q <= w_addr_inc;
            end

            if (state_q != ST_IDLE && in_cs_n) begin
                // Frame end; a coinciding rx byte is discarded.
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // Falling cs_n starts a frame. Placed after the read
                        // pipeline so the sync byte wins a same-cycle clash.
                        if (!in_cs_n && cs_prev_q) begin
                            state_q    <= ST_CMD;
                            tx_byte_q  <= SYNC_BYTE;
                            tx_valid_q <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        if (in_rx_valid) begin
                            if (!w_addr_legal) begin
                                state_q <= ST_DROP;
                                if (err_q != ERR_COUNT_MAX) begin
                                    err_q <= err_q + 8'd1;
                                end
                            end else begin
                                addr_q <= w_cmd_addr;
                                if (w_cmd_is_rd) begin
                                    state_q <= ST_READ;
                                    rd_en_q <= 1'b1;
                                end else begin
                                    state_q <= ST_WRITE;
                                end
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (in_rx_valid) begin
                            wdata_q <= in_rx_byte;
                            wr_en_q <= 1'b1;
                        end
                    end
                    ST_READ: begin
                        // Dummy byte: value ignored, fetch the next register.
                        if (in_rx_valid) begin
                            addr_q  <= w_addr_inc;
                            rd_en_q <= 1'b1;
                        end
                    end
                    ST_DROP: begin
                        // Swallow everything until cs_n rises.
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_tx_byte   = tx_byte_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_wr_en = wr_en_q;
    assign o_reg_rd_en = rd_en_q;
    assign o_err_count = err_q;

endmodule : spi_cmd_decoder
`default_nettype wire
